// File: rtl/jt6295_ctrlx_if.sv
// Bus bundle between jt6295_ctrlx and its surroundings: CPU write port,
// phrase-table ROM port and the channel-engine start/stop lines.
interface jt6295_ctrlx_if #(
    parameter int CH = 4,
    parameter int AW = 18,
    parameter int PW = 7
);
    logic          wrn;
    logic [7:0]    din;
    logic [PW+2:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] stop_addr;
    logic [3:0]    att;
    logic [CH-1:0] start;
    logic [CH-1:0] stop;
    logic [CH-1:0] busy;
    logic [CH-1:0] ack;
    logic          qfull;
    logic          ovf;

    modport master (
        input  wrn, din, rom_data, rom_ok, busy, ack,
        output rom_addr, start_addr, stop_addr, att, start, stop, qfull, ovf
    );

    modport slave (
        output wrn, din, rom_data, rom_ok, busy, ack,
        input  rom_addr, start_addr, stop_addr, att, start, stop, qfull, ovf
    );
endinterface

// File: rtl/jt6295_ctrlx.sv
// MSM6295-style command controller: CPU byte decode, command FIFO, phrase-table
// fetch and per-channel start/stop strobes. JT6295_BUSYCHK_EN blocks restarts of busy channels.

module jt6295_ctrlx_ch (
    input  logic clk,
    input  logic rst,
    input  logic cen4,
    input  logic stop_wr,
    input  logic issue,
    input  logic issue_bit,
    input  logic ack,
    input  logic busy,
    output logic start,
    output logic stop
);
    always_ff @(posedge clk) begin
        if (rst) begin
            start <= 1'b0;
            stop  <= 1'b0;
        end else begin
            // a stop write wins over housekeeping and cancels a pending start
            if (stop_wr)    stop <= 1'b1;
            else if (cen4)  stop <= stop & busy;
            if (stop_wr)    start <= 1'b0;
            else if (issue) start <= issue_bit;
            else if (ack)   start <= 1'b0;
        end
    end
endmodule

module jt6295_ctrlx #(
    parameter int CH = 4,
    parameter int AW = 18,
    parameter int PW = 7,
    parameter int QD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen4,
    jt6295_ctrlx_if.master   bus
);
    localparam int QA = $clog2(QD);
    localparam logic [QA:0] QFULL = QD[QA:0];

    typedef struct packed {
        logic [PW-1:0] phrase;
        logic [CH-1:0] mask;
        logic [3:0]    att;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

    state_t        state, state_nxt;
    logic          last_wrn, cmd, we, push, push_ok, pop, capture;
    logic [PW-1:0] phrase;
    logic [7:0]    din7;
    logic [CH-1:0] stop_bits, iss_vec, start_v, stop_v;
    cmd_t          q [QD];
    cmd_t          entry, cur;
    logic [QA-1:0] wr_ptr, rd_ptr;
    logic [QA:0]   count;
    logic [2:0]    lsb;
    logic          settle, ovf;
    logic [47:0]   sbuf;
    logic [23:0]   sbuf_hi, sbuf_lo;
    logic [AW-1:0] start_addr, stop_addr;
    logic [3:0]    att;

    assign we        = bus.wrn & ~last_wrn;
    assign din7      = {1'b0, bus.din[6:0]};
    assign push      = we & cmd;
    assign push_ok   = push & ((count != QFULL) | pop);
    assign stop_bits = (we & ~cmd & ~bus.din[7]) ? bus.din[3+CH-1:3] : '0;
    assign entry     = '{phrase: phrase, mask: bus.din[4+CH-1:4], att: bus.din[3:0]};
    assign capture   = (state == FETCH) & ~settle & bus.rom_ok;
    assign sbuf_hi   = sbuf[47:24];
    assign sbuf_lo   = sbuf[23:0];

`ifdef JT6295_BUSYCHK_EN
    assign iss_vec = cur.mask & ~bus.busy & ~stop_bits;
`else
    assign iss_vec = cur.mask & ~stop_bits;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop       = 1'b1;
                state_nxt = FETCH;
            end
            FETCH:   if (capture && lsb == 3'd5) state_nxt = ISSUE;
            ISSUE:   state_nxt = (iss_vec == '0) ? IDLE : WAIT;
            WAIT:    if (start_v == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) q[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wrn   <= 1'b1;
            cmd        <= 1'b0;
            phrase     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            cur        <= '0;
            lsb        <= '0;
            settle     <= 1'b0;
            sbuf       <= '0;
            start_addr <= '0;
            stop_addr  <= '0;
            att        <= '0;
        end else begin
            last_wrn <= bus.wrn;
            if (we) begin
                if (cmd) begin
                    cmd <= 1'b0;
                end else if (bus.din[7]) begin
                    phrase <= din7[PW-1:0];
                    cmd    <= 1'b1;
                end
            end
            if (push & ~push_ok) ovf <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                cur    <= q[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                lsb    <= '0;
                settle <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // first cycle after rom_addr moves is a settle cycle
            if (state == FETCH) begin
                if (settle) begin
                    settle <= 1'b0;
                end else if (bus.rom_ok) begin
                    sbuf   <= {sbuf[39:0], bus.rom_data};
                    settle <= 1'b1;
                    if (lsb != 3'd5) lsb <= lsb + 1'b1;
                end
            end
            if (state == ISSUE) begin
                start_addr <= sbuf_hi[AW-1:0];
                stop_addr  <= sbuf_lo[AW-1:0];
                att        <= cur.att;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        jt6295_ctrlx_ch u_ch (
            .clk       (clk),
            .rst       (rst),
            .cen4      (cen4),
            .stop_wr   (stop_bits[i]),
            .issue     (state == ISSUE),
            .issue_bit (iss_vec[i]),
            .ack       (bus.ack[i]),
            .busy      (bus.busy[i]),
            .start     (start_v[i]),
            .stop      (stop_v[i])
        );
    end

    assign bus.rom_addr   = {cur.phrase, lsb};
    assign bus.start_addr = start_addr;
    assign bus.stop_addr  = stop_addr;
    assign bus.att        = att;
    assign bus.start      = start_v;
    assign bus.stop       = stop_v;
    assign bus.qfull      = (count == QFULL);
    assign bus.ovf        = ovf;
endmodule

// File: tb/tb_jt6295_ctrlx.sv
// Directed bench for jt6295_ctrlx: a CH=4 instance plus a CH=2 instance fed the same CPU traffic.
module tb_jt6295_ctrlx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen4 = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    jt6295_ctrlx_if #(.CH(4), .AW(18), .PW(7)) ia ();
    jt6295_ctrlx_if #(.CH(2), .AW(18), .PW(7)) ib ();

    jt6295_ctrlx #(.CH(4), .AW(18), .PW(7), .QD(4)) u_a (.clk(clk), .rst(rst), .cen4(cen4), .bus(ia));
    jt6295_ctrlx #(.CH(2), .AW(18), .PW(7), .QD(4)) u_b (.clk(clk), .rst(rst), .cen4(cen4), .bus(ib));

    always #5 clk = ~clk;

    // phrase 5 holds the reference entry; others hold {phrase, 0, lsb}
    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        logic [6:0] p;
        logic [2:0] l;
        p = a[9:3];
        l = a[2:0];
        if (p == 7'd5) begin
            case (l)
                3'd0: return 8'h01;
                3'd1: return 8'h23;
                3'd2: return 8'h45;
                3'd3: return 8'h02;
                3'd4: return 8'h34;
                3'd5: return 8'h56;
                default: return 8'h00;
            endcase
        end
        return {p[3:0], 1'b0, l};
    endfunction

    assign ia.rom_data = rom_fn(ia.rom_addr);
    assign ib.rom_data = rom_fn(ib.rom_addr);
    assign ib.wrn      = ia.wrn;
    assign ib.din      = ia.din;
    assign ib.rom_ok   = ia.rom_ok;
    assign ib.busy     = ia.busy[1:0];
    assign ib.ack      = ia.ack[1:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] d);
        ia.din = d;
        ia.wrn = 1'b0;
        tick();
        ia.wrn = 1'b1;
        tick();
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (ia.start == '0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, ia.start != '0}, 32'd1);
    endtask

    task automatic ack_all();
        ia.ack = 4'hF;
        tick();
        ia.ack = 4'h0;
        ticks(3);
    endtask

    logic [17:0] exp_sa [5] = '{18'h01112, 18'h02122, 18'h03132, 18'h04142, 18'h06162};
    logic [6:0]  ph     [6] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd6, 7'd7};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        ia.wrn = 1'b1; ia.din = 8'h00; ia.rom_ok = 1'b1; ia.busy = 4'h0; ia.ack = 4'h0;
        ticks(3);
        chk("rst_start",  ia.start, 0);
        chk("rst_stop",   ia.stop, 0);
        chk("rst_romadr", ia.rom_addr, 0);
        chk("rst_qfull",  ia.qfull, 0);
        chk("rst_ovf",    ia.ovf, 0);
        chk("rst_saddr",  ia.start_addr, 0);
        rst = 1'b0;
        ticks(2);

        // reference start, latency 15 cycles from the second write edge
        wr(8'h85);
        wr(8'h13);
        ticks(13);
        chk("lat_early", ia.start, 4'b0000);
        tick();
        chk("lat_start", ia.start, 4'b0001);
        chk("ref_saddr", ia.start_addr, 18'h12345);
        chk("ref_eaddr", ia.stop_addr, 18'h23456);
        chk("ref_att",   ia.att, 4'd3);
        ia.ack = 4'b0001;
        tick();
        ia.ack = 4'b0000;
        chk("ack_clear", ia.start, 4'b0000);
        ticks(3);

        // stop write and cen4 housekeeping
        ia.busy = 4'b1001;
        wr(8'h48);
        chk("stop_set", ia.stop, 4'b1001);
        cen4 = 1'b1;
        tick();
        chk("stop_hold", ia.stop, 4'b1001);
        ia.busy = 4'b0000;
        tick();
        cen4 = 1'b0;
        chk("stop_clr", ia.stop, 4'b0000);
        ticks(2);

        // FIFO fill / overflow: first command sits in WAIT, next four buffer, sixth drops
        for (int i = 0; i < 6; i++) begin
            wr({1'b1, ph[i]});
            wr(8'h10 | 8'(i + 1));
            if (i == 3) chk("qfull_lo", ia.qfull, 0);
            if (i == 4) begin
                chk("qfull_hi", ia.qfull, 1);
                chk("ovf_lo",   ia.ovf, 0);
            end
        end
        chk("ovf_hi",   ia.ovf, 1);
        chk("qfull_ov", ia.qfull, 1);
        for (int k = 0; k < 5; k++) begin
            wait_start("q_issue");
            chk("q_att",   ia.att, 32'(k + 1));
            chk("q_saddr", ia.start_addr, exp_sa[k]);
            ia.ack = 4'b0001;
            tick();
            ia.ack = 4'b0000;
        end
        ticks(30);
        chk("q_drop",   ia.start, 4'b0000);
        chk("q_empty",  ia.qfull, 0);
        chk("ovf_stky", ia.ovf, 1);

        // second byte with bit7 set is still a channel byte; phrase kept
        wr(8'h82);
        wr(8'hF0);
        wait_start("f0_issue");
        chk("f0_start", ia.start, 4'b1111);
        chk("f0_att",   ia.att, 0);
        chk("f0_saddr", ia.start_addr, 18'h02122);
        chk("f0_ch2",   ib.start, 2'b11);
        ack_all();

        // busy filtering
        ia.busy = 4'b0010;
        wr(8'h81);
        wr(8'h30);
        wait_start("bz_issue");
`ifdef JT6295_BUSYCHK_EN
        chk("bz_start", ia.start, 4'b0001);
`else
        chk("bz_start", ia.start, 4'b0011);
`endif
        ack_all();
        ia.busy = 4'b0000;

        // stop write cancels a pending start
        wr(8'h81);
        wr(8'h10);
        wait_start("cx_issue");
        wr(8'h08);
        chk("cx_start", ia.start, 4'b0000);
        chk("cx_stop",  ia.stop, 4'b0001);
        cen4 = 1'b1;
        tick();
        cen4 = 1'b0;
        ticks(3);

        // reset during a stalled fetch
        ia.rom_ok = 1'b0;
        wr(8'h81);
        wr(8'h10);
        wr(8'h82);
        wr(8'h10);
        ticks(4);
        chk("stall_adr", ia.rom_addr, 10'h008);
        rst = 1'b1;
        tick();
        chk("mr_start", ia.start, 0);
        chk("mr_adr",   ia.rom_addr, 0);
        chk("mr_saddr", ia.start_addr, 0);
        chk("mr_ovf",   ia.ovf, 0);
        rst = 1'b0;
        ia.rom_ok = 1'b1;
        ticks(30);
        chk("mr_flush", ia.start, 0);
        wr(8'h83);
        wr(8'h25);
        wait_start("mr_issue");
        chk("mr_new",   ia.start, 4'b0010);
        chk("mr_att",   ia.att, 4'd5);
        chk("mr_sa",    ia.start_addr, 18'h03132);
        chk("mr_ea",    ia.stop_addr, 18'h33435);
        ack_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
